// File: rtl/adc_metric_acc.sv
// rtl/adc_metric_acc.sv - settle-then-average ADC window accumulator producing J+, J- and their difference
module adc_metric_acc #(
   parameter int DATA_WIDTH    = 14,
   parameter int LOG2_SAMPLES  = 4,
   parameter int SETTLE_CYCLES = 7
) (
   input  logic                         adc_clk,
   input  logic                         rst_n,
   input  logic signed [DATA_WIDTH-1:0] adc_data,
   input  logic                         start,
   input  logic                         sel,
   input  logic                         abort,
   output logic                         busy,
   output logic                         done,
   output logic signed [DATA_WIDTH-1:0] jp_out,
   output logic signed [DATA_WIDTH-1:0] jm_out,
   output logic signed [DATA_WIDTH:0]   dj_out
);

   localparam int ACC_W   = DATA_WIDTH + LOG2_SAMPLES;
   localparam int NSAMP   = 2 ** LOG2_SAMPLES;
   localparam int CNT_MAX = (SETTLE_CYCLES > NSAMP) ? SETTLE_CYCLES : NSAMP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'(NSAMP - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic                     sel_q;
   logic [DATA_WIDTH-1:0]    avg;
   logic [ACC_W-1:0]         sample_ext;

   // Dropping the low LOG2_SAMPLES bits is an arithmetic shift, i.e. floor toward -inf.
   assign avg        = acc_q[ACC_W-1:LOG2_SAMPLES];
   assign sample_ext = {{LOG2_SAMPLES{adc_data[DATA_WIDTH-1]}}, adc_data};
   assign busy       = (state_q != IDLE);

   // State register.
   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; the DONE cycle can accept a new start for back-to-back windows.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SETTLE;
         SETTLE:  if (abort) state_d = IDLE;
                  else if (cnt_q == SETTLE_LAST) state_d = ACCUM;
         ACCUM:   if (abort) state_d = IDLE;
                  else if (cnt_q == ACCUM_LAST) state_d = DONE;
         DONE:    state_d = start ? SETTLE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: counter, accumulator, latched select and result registers.
   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         sel_q  <= 1'b0;
         done   <= 1'b0;
         jp_out <= '0;
         jm_out <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (state_q == DONE) begin
                  done <= 1'b1;
                  if (sel_q) jm_out <= avg;
                  else       jp_out <= avg;
               end
               if (start) begin
                  sel_q <= sel;
                  acc_q <= '0;
                  cnt_q <= '0;
               end
            end
            SETTLE: begin
               if (!abort) cnt_q <= (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
            end
            ACCUM: begin
               if (!abort) begin
                  acc_q <= acc_q + $signed(sample_ext);
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: cnt_q <= '0;
         endcase
      end
   end

   // Difference tracks the result registers one edge behind, at full width.
   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) dj_out <= '0;
      else        dj_out <= {jp_out[DATA_WIDTH-1], jp_out} - {jm_out[DATA_WIDTH-1], jm_out};
   end

endmodule

// File: tb/tb_adc_metric_acc.sv
// tb/tb_adc_metric_acc.sv - directed self-checking bench for adc_metric_acc
module tb_adc_metric_acc;

   logic               adc_clk = 1'b0;
   logic               rst_n   = 1'b0;
   logic signed [13:0] adc_data = '0;
   logic               start = 1'b0;
   logic               sel   = 1'b0;
   logic               abort = 1'b0;
   logic               busy;
   logic               done;
   logic signed [13:0] jp_out;
   logic signed [13:0] jm_out;
   logic signed [14:0] dj_out;

   int passes = 0;
   int total  = 0;
   int ndone, done_e1, done_e2;
   int cval;
   logic busy_e1, busy_at_abort;
   longint dj_at_done, dj_after;

   adc_metric_acc #(.DATA_WIDTH(14), .LOG2_SAMPLES(4), .SETTLE_CYCLES(7)) dut (
      .adc_clk(adc_clk), .rst_n(rst_n), .adc_data(adc_data), .start(start), .sel(sel),
      .abort(abort), .busy(busy), .done(done), .jp_out(jp_out), .jm_out(jm_out), .dj_out(dj_out)
   );

   always #5 adc_clk = ~adc_clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // mode 0: cval inside the sample window, junk elsewhere; 1: ramp 0..15; 2: ramp 0..-15; 3: cval always
   function automatic int data_at(input int mode, input int e);
      if (mode == 3) return cval;
      if (e < 8 || e > 23) return 4321;
      case (mode)
         1:       return e - 8;
         2:       return 8 - e;
         default: return cval;
      endcase
   endfunction

   // Edge 0 accepts start; edges 1..n_edges follow. smode 1 pulses start at 3 and 10 with sel flipped, smode 2 holds start to edge 47.
   task automatic run(input logic sel_v, input int mode, input int smode, input int abort_e, input int n_edges);
      ndone = 0; done_e1 = -1; done_e2 = -1;
      sel = sel_v; start = 1'b1; adc_data = 14'(data_at(mode, 0));
      @(posedge adc_clk); #1;
      for (int e = 1; e <= n_edges; e++) begin
         adc_data = 14'(data_at(mode, e));
         start = (smode == 2) ? (e <= 47) : (smode == 1) ? (e == 3 || e == 10) : 1'b0;
         sel   = (smode == 1) ? ~sel_v : sel_v;
         abort = (e == abort_e);
         @(posedge adc_clk); #1;
         if (e == 1) busy_e1 = busy;
         if (e == abort_e) busy_at_abort = busy;
         if (done) begin
            ndone++;
            if (done_e1 < 0) begin done_e1 = e; dj_at_done = dj_out; end
            else if (done_e2 < 0) done_e2 = e;
         end
         if (done_e1 >= 0 && e == done_e1 + 1) dj_after = dj_out;
      end
      start = 1'b0; abort = 1'b0; sel = 1'b0;
   endtask

   initial begin
      #2;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_jp", jp_out, 0);
      chk("reset_dj", dj_out, 0);
      @(posedge adc_clk); #3; rst_n = 1'b1;
      @(posedge adc_clk); #1;

      cval = 1000; run(1'b0, 0, 0, -1, 26);
      chk("w1_busy_e1", busy_e1, 1);
      chk("w1_done_edge", done_e1, 24);
      chk("w1_ndone", ndone, 1);
      chk("w1_jp", jp_out, 1000);
      chk("w1_jm", jm_out, 0);
      chk("w1_dj_at_done", dj_at_done, 0);
      chk("w1_dj_next", dj_after, 1000);
      chk("w1_busy_end", busy, 0);

      cval = -200; run(1'b1, 0, 0, -1, 26);
      chk("w2_jm", jm_out, -200);
      chk("w2_jp", jp_out, 1000);
      chk("w2_dj", dj_out, 1200);

      run(1'b0, 1, 0, -1, 26);
      chk("ramp_jp", jp_out, 7);
      chk("ramp_dj", dj_out, 207);
      run(1'b1, 2, 0, -1, 26);
      chk("negramp_floor_jm", jm_out, -8);
      chk("negramp_dj", dj_out, 15);
      cval = -1; run(1'b0, 0, 0, -1, 26);
      chk("minus1_jp", jp_out, -1);
      cval = 8191; run(1'b0, 0, 0, -1, 26);
      chk("max_jp", jp_out, 8191);
      cval = -8192; run(1'b1, 0, 0, -1, 26);
      chk("min_jm", jm_out, -8192);
      chk("extreme_dj", dj_out, 16383);

      cval = 300; run(1'b0, 0, 1, -1, 50);
      chk("ign_ndone", ndone, 1);
      chk("ign_done_edge", done_e1, 24);
      chk("ign_jp", jp_out, 300);
      chk("ign_jm", jm_out, -8192);

      cval = 500; run(1'b0, 3, 2, -1, 60);
      chk("b2b_ndone", ndone, 2);
      chk("b2b_e1", done_e1, 24);
      chk("b2b_e2", done_e2, 48);
      chk("b2b_jp", jp_out, 500);

      cval = 900; run(1'b0, 0, 0, 13, 30);
      chk("abort_busy", busy_at_abort, 0);
      chk("abort_ndone", ndone, 0);
      chk("abort_jp", jp_out, 500);
      chk("abort_dj", dj_out, 8692);

      cval = 700; sel = 1'b1; start = 1'b1; adc_data = 14'(cval);
      @(posedge adc_clk); #1; start = 1'b0;
      for (int e = 1; e <= 15; e++) begin @(posedge adc_clk); #1; end
      #1; rst_n = 1'b0; #1;
      chk("rst_jp", jp_out, 0);
      chk("rst_jm", jm_out, 0);
      chk("rst_dj", dj_out, 0);
      chk("rst_busy", busy, 0);
      @(posedge adc_clk); #3; rst_n = 1'b1;
      ndone = 0;
      for (int e = 0; e < 30; e++) begin @(posedge adc_clk); #1; if (done) ndone++; end
      chk("rst_no_done", ndone, 0);

      cval = 250; run(1'b0, 0, 0, -1, 26);
      chk("post_rst_done_edge", done_e1, 24);
      chk("post_rst_jp", jp_out, 250);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
